// File: rtl/layer_sequencer.sv
// Sequences one shared layer engine across up to MAX_LAYERS layers with ping-pong activation banks.
// Optional watchdog on the RUN wait: define LAYER_SEQ_WATCHDOG_EN.
module layer_sequencer #(
  parameter int MAX_LAYERS = 4,
  parameter int LW         = 2,
  parameter int TIMEOUT    = 1023,
  parameter int TW         = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [LW:0]   num_layers,
  input  logic          eng_done,
  output logic          eng_reset,
  output logic [LW-1:0] layer_idx,
  output logic          in_sel,
  output logic          buf_rd,
  output logic          act_we,
  output logic          busy,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_CAPTURE, S_FINISH} state_t;

  localparam logic [LW:0] MAX_N = (LW+1)'(MAX_LAYERS);

  state_t        state, state_nxt;
  logic [LW:0]   n_q, n_nxt, n_clip;
  logic [LW-1:0] layer_nxt;
  logic          in_sel_nxt, buf_nxt;
  logic          last, wd_trip;

  assign n_clip = (num_layers > MAX_N) ? MAX_N : num_layers;
  assign last   = ({1'b0, layer_idx} == (n_q - (LW+1)'(1)));

  // Strobes and engine reset decode from state only, so nothing here is combinational from inputs.
  assign eng_reset = !((state == S_RUN) || (state == S_CAPTURE));
  assign act_we    = (state == S_CAPTURE);
  assign done      = (state == S_FINISH);
  assign busy      = (state != S_IDLE);

`ifdef LAYER_SEQ_WATCHDOG_EN
  logic [TW-1:0] wd_cnt;
  logic          err_q;

  assign wd_trip = (state == S_RUN) && !eng_done && (wd_cnt == TW'(TIMEOUT - 1));
  assign error   = err_q;

  // Held at zero outside RUN, so it restarts on every entry to RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      wd_cnt <= (state == S_RUN) ? wd_cnt + TW'(1) : '0;
      if (state == S_IDLE && start) err_q <= 1'b0;
      else if (wd_trip)             err_q <= 1'b1;
    end
  end
`else
  assign wd_trip = 1'b0;
  assign error   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      n_q       <= '0;
      layer_idx <= '0;
      in_sel    <= 1'b0;
      buf_rd    <= 1'b0;
    end else begin
      state     <= state_nxt;
      n_q       <= n_nxt;
      layer_idx <= layer_nxt;
      in_sel    <= in_sel_nxt;
      buf_rd    <= buf_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    n_nxt      = n_q;
    layer_nxt  = layer_idx;
    in_sel_nxt = in_sel;
    buf_nxt    = buf_rd;
    case (state)
      S_IDLE: begin
        if (start) begin
          n_nxt      = n_clip;
          layer_nxt  = '0;
          in_sel_nxt = 1'b0;
          buf_nxt    = 1'b0;
          state_nxt  = (n_clip == '0) ? S_FINISH : S_LOAD;
        end
      end
      S_LOAD: state_nxt = S_RUN;
      S_RUN: begin
        if (eng_done)     state_nxt = S_CAPTURE;
        else if (wd_trip) state_nxt = S_IDLE;
      end
      S_CAPTURE: begin
        if (last) begin
          state_nxt = S_FINISH;
        end else begin
          // The bank just written becomes the next layer's input.
          layer_nxt  = layer_idx + LW'(1);
          buf_nxt    = !buf_rd;
          in_sel_nxt = 1'b1;
          state_nxt  = S_LOAD;
        end
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Control FSM that time-shares a single `layer` engine (matrix multiply followed by ReLU) across a multi-layer network. It selects the weight/bias bank and input source for each layer and holds the engine in reset between layers. It waits for the engine's `done`, then strobes the result into a ping-pong activation buffer. It sits between the top-level inference controller (start/done handshake) and the shared `layer` datapath plus its weight ROM and activation buffers.

## Interface
- `MAX_LAYERS`, default 4: number of weight/bias banks available.
- `LW`, default 2: width of layer index; `2**LW >= MAX_LAYERS`.
- `TIMEOUT`, default 1023: watchdog limit in RUN cycles (used only with the watchdog macro).
- `TW`, default 10: watchdog counter width.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `start`  in  1  begin inference; sampled only in IDLE.
- `num_layers`  in  LW+1  layers to run; latched on accepted `start`.
- `eng_done`  in  1  `done` from the `layer` engine; level, valid while engine out of reset.
- `eng_reset`  out  1  drives the engine's `reset`; high = engine cleared/held.
- `layer_idx`  out  LW  weight/bias bank select for the engine's `M`/`b`.
- `in_sel`  out  1  engine `x` source: 0 = external input, 1 = activation buffer `buf_rd`.
- `buf_rd`  out  1  activation buffer bank feeding the engine when `in_sel`=1.
- `act_we`  out  1  one-cycle write strobe, engine `y` → buffer bank `~buf_rd`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the final layer is captured.
- `error`  out  1  sticky watchdog flag; cleared on reset or accepted `start`.

## Operation
- States: IDLE, LOAD, RUN, CAPTURE, FINISH.
- IDLE: `eng_reset`=1, `busy`=0.
  - On `start`=1, latch `n = min(num_layers, MAX_LAYERS)`, set `layer_idx`=0, `in_sel`=0, `buf_rd`=0, and clear `error`.
  - If `n`=0, go to FINISH; otherwise go to LOAD.
- LOAD, exactly 1 cycle: `eng_reset`=1 with the new `layer_idx`/`in_sel` stable. Go to RUN.
- RUN: `eng_reset`=0. When `eng_done`=1, go to CAPTURE.
- CAPTURE, 1 cycle: `act_we`=1 with `eng_reset` still 0, so `y` stays valid.
  - If `layer_idx == n-1`, go to FINISH.
  - Otherwise: `layer_idx`++, `buf_rd` toggles (the just-written bank becomes the read bank), `in_sel`=1, go to LOAD.
- FINISH, 1 cycle: `done`=1, `eng_reset`=1. Go to IDLE.
- `start` while `busy` is ignored.
- `num_layers` changes after acceptance have no effect.
- Final result lives in bank `~buf_rd` as of the last CAPTURE. This is bank `(n-1)%2==0 ? 1 : 0`.

## Timing
- Reset values: state IDLE, `eng_reset`=1, `layer_idx`=0, `in_sel`=0, `buf_rd`=0, `act_we`=0, `busy`=0, `done`=0, `error`=0.
- All outputs are registered or decoded from registered state only. No combinational path from `eng_done` or `start` to any output.
- `start` at edge k → LOAD during cycle k+1 → RUN from k+2.
- `eng_done` seen high at edge j → `act_we` high during cycle j+1.
  - Next layer's LOAD runs in cycle j+2, or FINISH in j+2 on the last layer.
- Per-layer overhead beyond engine latency: 2 cycles (LOAD + CAPTURE).
- Engine is out of reset only in RUN and CAPTURE, so stale `eng_done` cannot be observed in RUN.
- `reset` asserted in any state returns to IDLE on that edge. No `done` or `act_we` is issued.

## Configuration
- `LAYER_SEQ_WATCHDOG_EN` defined:
  - A `TW`-bit counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches `TIMEOUT` with `eng_done`=0: set `error`=1, go to IDLE with `eng_reset`=1, and issue no `done`.
- Not defined: no counter is built, `error` is tied 0, and RUN waits indefinitely.

## Test plan
- Reset, then idle 5 cycles → `eng_reset`=1, `busy`=0, all strobes 0.
- `num_layers`=3, engine model raises `eng_done` 4 cycles after `eng_reset` falls → three `act_we` pulses with `layer_idx` 0, 1, 2 and `in_sel` 0, 1, 1; `buf_rd` 0, 1, 0; `done` 1 cycle after the 3rd `act_we`; total 20 cycles start-to-`done`.
- `num_layers`=0 → `done` 2 cycles after `start`, no `act_we`, `eng_reset` never low. `num_layers`=7 with `MAX_LAYERS`=4 → exactly 4 layers run.
- `start` pulsed during RUN of layer 1 → ignored; sequence and `done` timing identical to the unperturbed run.
- `reset` asserted in CAPTURE of layer 1 → next cycle IDLE, `act_we`=0, `layer_idx`=0; a new `start` runs cleanly from layer 0.
- With `LAYER_SEQ_WATCHDOG_EN`, `TIMEOUT`=8, `eng_done` held 0 → `error`=1 after 8 RUN cycles, return to IDLE, no `done`; next `start` clears `error`.
